// File: rtl/paddle_key_conditioner.sv
// Conditions the four raw DE1-SoC pushbuttons into debounced levels, press/release
// pulses and active-low paddle commands with per-paddle opposing-key lockout.
module paddle_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  output logic [3:0] key_down,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] paddle_n
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]           s1;
  logic [3:0]           s2;
  logic [3:0]           db;
  logic [3:0]           db_next;
  logic [3:0]           held_next;
  logic [3:0]           paddle_next;
  logic [CNT_WIDTH-1:0] cnt      [4];
  logic [CNT_WIDTH-1:0] cnt_next [4];

  // A change is accepted only after s2 has disagreed with db for DEBOUNCE_CYCLES
  // consecutive samples; any agreeing sample restarts the count from zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_next[i]  = db[i];
      cnt_next[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Holding both keys of a paddle cancels its motion; the two paddles are independent.
  always_comb begin
    held_next   = ~db_next;
    paddle_next = db_next;
    if (held_next[3] && held_next[2]) paddle_next[3:2] = 2'b11;
    if (held_next[1] && held_next[0]) paddle_next[1:0] = 2'b11;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1          <= 4'b1111;
      s2          <= 4'b1111;
      db          <= 4'b1111;
      key_down    <= 4'b0000;
      key_press   <= 4'b0000;
      key_release <= 4'b0000;
      paddle_n    <= 4'b1111;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1          <= key_n;
      s2          <= s1;
      db          <= db_next;
      key_down    <= ~db_next;
      key_press   <= db & ~db_next;
      key_release <= ~db & db_next;
      paddle_n    <= paddle_next;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_paddle_key_conditioner.sv
// Bench for paddle_key_conditioner: spec-derived vector table, directed corner
// sequences and randomized key activity checked against a windowed reference model.
module tb_paddle_key_conditioner;

  localparam int D  = 4;
  localparam int D2 = 37;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] key_n = 4'b1111;
  logic [3:0] key_down, key_press, key_release, paddle_n;
  logic [3:0] key_n2 = 4'b1111;
  logic [3:0] key_down2, key_press2, key_release2, paddle_n2;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  paddle_key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(18)) u_dut (
    .clk(clk), .resetn(resetn), .key_n(key_n), .key_down(key_down),
    .key_press(key_press), .key_release(key_release), .paddle_n(paddle_n)
  );

  paddle_key_conditioner #(.DEBOUNCE_CYCLES(D2), .CNT_WIDTH(18)) u_dut_long (
    .clk(clk), .resetn(resetn), .key_n(key_n2), .key_down(key_down2),
    .key_press(key_press2), .key_release(key_release2), .paddle_n(paddle_n2)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [3:0]  samp_q[$];
  logic [3:0]  s2_q[$];
  logic [3:0]  m_db;

  function automatic logic [15:0] outs();
    return {key_down, key_press, key_release, paddle_n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    s2_q.delete();
    exp_q.delete();
    m_db = 4'b1111;
  endtask

  // A key's accepted level flips once the last D synchronised samples all disagree with it.
  task automatic model_edge(input logic [3:0] k);
    logic [3:0] s2_pre, new_db, held, pad, smp;
    bit all_diff;
    int n;
    n = samp_q.size();
    s2_pre = (n >= 2) ? samp_q[n-2] : 4'b1111;
    s2_q.push_back(s2_pre);
    new_db = m_db;
    for (int b = 0; b < 4; b++) begin
      if (s2_q.size() >= D) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          smp = s2_q[s2_q.size() - 1 - j];
          if (smp[b] == m_db[b]) all_diff = 1'b0;
        end
        if (all_diff) new_db[b] = ~m_db[b];
      end
    end
    held = ~new_db;
    pad  = new_db;
    if (held[3] && held[2]) pad[3:2] = 2'b11;
    if (held[1] && held[0]) pad[1:0] = 2'b11;
    exp_q.push_back({~new_db, m_db & ~new_db, ~m_db & new_db, pad});
    m_db = new_db;
    samp_q.push_back(k);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives key_n, lets one rising edge pass, checks at the next falling edge.
  task automatic step(input logic [3:0] k);
    logic [15:0] e;
    key_n = k;
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    e = exp_q.pop_front();
    check("model", outs(), e);
  endtask

  typedef struct {
    logic [3:0]  key;
    int          hold;
    logic [15:0] exp;   // {key_down, key_press, key_release, paddle_n} after last cycle
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [3:0] cur;
    bit saw_press;
    int found;

    vecs[0] = '{4'b1111, 8, {4'b0000, 4'b0000, 4'b0000, 4'b1111}};
    vecs[1] = '{4'b1011, 5, {4'b0000, 4'b0000, 4'b0000, 4'b1111}};
    vecs[2] = '{4'b1011, 1, {4'b0100, 4'b0100, 4'b0000, 4'b1011}};
    vecs[3] = '{4'b1011, 1, {4'b0100, 4'b0000, 4'b0000, 4'b1011}};
    vecs[4] = '{4'b1111, 6, {4'b0000, 4'b0000, 4'b0100, 4'b1111}};
    vecs[5] = '{4'b1100, 6, {4'b0011, 4'b0011, 4'b0000, 4'b1111}};
    vecs[6] = '{4'b1101, 6, {4'b0010, 4'b0000, 4'b0001, 4'b1101}};
    vecs[7] = '{4'b0001, 6, {4'b1110, 4'b1100, 4'b0000, 4'b1101}};
    vecs[8] = '{4'b0100, 6, {4'b1011, 4'b0001, 4'b0100, 4'b0111}};
    vecs[9] = '{4'b1111, 6, {4'b0000, 4'b0000, 4'b1011, 4'b1111}};

    // Reset holds outputs cleared even with every key pressed.
    key_n  = 4'b0000;
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", outs(), {4'b0000, 4'b0000, 4'b0000, 4'b1111});
    end
    key_n  = 4'b0111;
    resetn = 1'b1;
    model_reset();
    for (int i = 1; i <= 7; i++) begin
      step(4'b0111);
      if (i == 5) check("reset_edge5", outs(), {4'b0000, 4'b0000, 4'b0000, 4'b1111});
      if (i == 6) check("reset_edge6", outs(), {4'b1000, 4'b1000, 4'b0000, 4'b0111});
      if (i == 7) check("reset_edge7", outs(), {4'b1000, 4'b0000, 4'b0000, 4'b0111});
    end
    repeat (6) step(4'b1111);

    // Table vectors.
    for (int v = 0; v < 10; v++) begin
      repeat (vecs[v].hold) step(vecs[v].key);
      check($sformatf("vec%0d", v), outs(), vecs[v].exp);
    end

    // Bounce on key 2: 2-cycle levels never reach the debounce threshold.
    saw_press = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step(4'b1011); saw_press |= (key_press != 4'b0000);
      step(4'b1011); saw_press |= (key_press != 4'b0000);
      step(4'b1111); saw_press |= (key_press != 4'b0000);
      step(4'b1111); saw_press |= (key_press != 4'b0000);
    end
    check("bounce_no_press", {31'b0, saw_press}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(4'b1011);
      if (i == 5) check("bounce_edge5", {key_press, paddle_n}, {4'b0000, 4'b1111});
      if (i == 6) check("bounce_edge6", {key_press, paddle_n}, {4'b0100, 4'b1011});
      if (i == 8) check("bounce_hold", {key_press, paddle_n}, {4'b0000, 4'b1011});
    end
    repeat (6) step(4'b1111);

    // Release of key 0.
    repeat (6) step(4'b1110);
    for (int i = 1; i <= 6; i++) begin
      step(4'b1111);
      if (i == 5) check("release_edge5", outs(), {4'b0001, 4'b0000, 4'b0000, 4'b1110});
      if (i == 6) check("release_edge6", outs(), {4'b0000, 4'b0000, 4'b0001, 4'b1111});
    end

    // Asynchronous reset while a key is held and accepted.
    repeat (8) step(4'b0111);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_async", outs(), {4'b0000, 4'b0000, 4'b0000, 4'b1111});
    @(negedge clk);
    check("midreset_hold", outs(), {4'b0000, 4'b0000, 4'b0000, 4'b1111});
    resetn = 1'b1;
    model_reset();
    for (int i = 1; i <= 7; i++) begin
      step(4'b0111);
      if (i == 5) check("midreset_edge5", outs(), {4'b0000, 4'b0000, 4'b0000, 4'b1111});
      if (i == 6) check("midreset_edge6", outs(), {4'b1000, 4'b1000, 4'b0000, 4'b0111});
    end
    repeat (6) step(4'b1111);

    // Randomized key activity with bounce-length and long holds.
    cur = 4'b1111;
    for (int t = 0; t < 80; t++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 2) == 0) cur[b] = ~cur[b];
      repeat ($urandom_range(1, 7)) step(cur);
    end
    repeat (8) step(4'b1111);

    // Longer debounce setting: press must appear exactly DEBOUNCE_CYCLES+2 edges after first sample.
    found = 0;
    key_n2 = 4'b0111;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_press2 != 4'b0000 && found == 0) begin
        found = e;
        check("long_press_bits", {28'b0, key_press2}, 32'h8);
      end
    end
    check("long_latency", found, D2 + 2);
    check("long_paddle", {28'b0, paddle_n2}, 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_key_conditioner.md
Name: paddle_key_conditioner

Overview:
Upstream input stage between the raw DE1-SoC KEY[3:0] pins and the game datapath's paddle inputs. Per key, it:
- synchronises the pin into the clock domain,
- debounces it,
- produces press/release event pulses,
- applies opposing-key lockout per paddle.

The paddle_n outputs keep the datapath's active-low convention, so they connect directly to paddle1Up/paddle1Down/paddle2Up/paddle2Down.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a synchronised key must differ from its stable state before the change is accepted (5 ms at 50 MHz); legal range 2..2^CNT_WIDTH-1
- CNT_WIDTH, 18, width of each per-key debounce counter

Ports:
- clk  input  1  system clock (CLOCK_50)
- resetn  input  1  asynchronous, active-low reset
- key_n  input  4  raw pushbuttons, active-low; [3]=P1 up, [2]=P1 down, [1]=P2 up, [0]=P2 down
- key_down  output  4  debounced level, active-high (1 = held)
- key_press  output  4  one-cycle pulse, debounced press accepted
- key_release  output  4  one-cycle pulse, debounced release accepted
- paddle_n  output  4  active-low move commands after lockout; same bit mapping as key_n

Behaviour:
- All state is in clk posedge flops with async clear on resetn=0. One clock only; no derived clocks.
- Reset values:
  - sync stage 1 and stage 2 = 4'b1111
  - stable state db = 4'b1111 (released)
  - counters = 0
  - key_down = 0, key_press = 0, key_release = 0, paddle_n = 4'b1111
- Synchroniser: two-flop chain per bit, s1 <= key_n, s2 <= s1. Only s2 is used downstream.
- Debounce, per key i, independent:
  - If s2[i]==db[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: db[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a clean raw change first sampled at edge 1 updates db at edge DEBOUNCE_CYCLES+2. For DEBOUNCE_CYCLES=4 that is edge 6.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES cycles at s2 returns s2 to db, clears the counter, and never changes db. The count restarts from 0 on each new difference.
- key_down = ~db, registered. It changes on the same edge as db.
- key_press[i] = 1 for exactly the one cycle following a db[i] 1->0 transition. key_release[i] is the same for a 0->1 transition. Never both at once. No repeat pulses while a key is held.
- Lockout, per pair (3,2) and (1,0):
  - Both keys held: both paddle_n bits of the pair = 1, meaning no motion.
  - Otherwise: paddle_n bit = db bit.
  - paddle_n is registered and updates on the same edge as db/key_down.
  - The two pairs are independent; a lockout on P1 never affects P2.
- Simultaneous events: several keys may transition on the same edge. All corresponding pulse bits assert together.
- Reset mid-debounce: all counters and outputs clear immediately and asynchronously. A key still held at deassertion is re-accepted only after the full DEBOUNCE_CYCLES+2 latency. It then produces one key_press pulse.
- Counter never wraps, because it is cleared at DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset: resetn=0 with key_n=4'b0000 → key_down=0, key_press=0, key_release=0, paddle_n=4'b1111 throughout. Release resetn holding key_n=4'b0111 → key_down=4'b1000 and paddle_n=4'b0111 at edge 6 after release; key_press=4'b1000 for one cycle only.
- Bounce: key_n[2] toggles 0,1,0,1 with 2-cycle periods, then holds 0 → no key_press during the toggling. Single key_press[2] pulse 6 edges after the final 1->0; paddle_n[2]=0 from then on.
- Release: hold key_n[0]=0 until accepted, then set it to 1 → key_release[0] pulse and paddle_n[0]=1 at edge 6 after the change. key_down[0] falls on that same edge.
- Lockout: press key_n[1] and key_n[0] on the same cycle → key_down=4'b0011, key_press=4'b0011 pulse, paddle_n[1:0]=2'b11. Release key_n[0] → paddle_n[1:0]=2'b01 six edges later. paddle_n[3:2] stays 2'b11.
- Independence: P1 up held while P2 up and down both held → paddle_n=4'b0111.
- Default latency: DEBOUNCE_CYCLES=250000, one clean press → key_press asserts exactly 250002 edges after first sample, never earlier.
